bird_motion_ctrl: RTL and testbench

Generates the one-cycle `flap` (move up) and `fall` (move down) strobes that drive the column of bird light cells. It converts the raw flap key into a clean single-cycle event and produces periodic gravity pulses. It sequences the game through idle, play and dead states. It sits between the key input and the bird light column, and it is the source of the `in`/`fall` inputs that every bird light cell consumes.

---
 rtl/bird_pkg.sv | 12 +
 rtl/bird_motion_ctrl_key_pulse.sv | 50 +++++
 rtl/bird_motion_ctrl.sv | 97 +++++++++
 tb/tb_bird_motion_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared types and constants for the bird motion controller.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } bird_state_t;

    localparam int BIRD_FALL_PERIOD_DEFAULT = 25_000_000;

endpackage

// File: rtl/bird_motion_ctrl_key_pulse.sv
// Flap key conditioning: optional two-flop synchronizer (BIRD_KEY_SYNC_EN) and
// rising-edge detector producing one key_event per press.
import bird_pkg::*;

module key_pulse (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic key_event
);

    logic s1_q, s1_d;
`ifdef BIRD_KEY_SYNC_EN
    logic s2_q, s2_d;
`endif
    logic kdly_q, kdly_d;
    logic k_s;

    // Next-state of the key pipeline and selection of the conditioned key.
    always_comb begin
        s1_d = key;
`ifdef BIRD_KEY_SYNC_EN
        s2_d = s1_q;
        k_s  = s2_q;
`else
        k_s  = s1_q;
`endif
        kdly_d = k_s;
    end

    // Key pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
`ifdef BIRD_KEY_SYNC_EN
            s2_q   <= 1'b0;
`endif
            kdly_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
`ifdef BIRD_KEY_SYNC_EN
            s2_q   <= s2_d;
`endif
            kdly_q <= kdly_d;
        end
    end

    assign key_event = k_s & ~kdly_q;

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird motion controller: game FSM, gravity counter and flap/fall strobes.
// Build option BIRD_KEY_SYNC_EN adds a two-flop key synchronizer.
import bird_pkg::*;

module bird_motion_ctrl #(
    parameter int FALL_PERIOD = BIRD_FALL_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    input  logic hit,
    output logic flap,
    output logic fall,
    output logic playing,
    output logic dead
);

    localparam int CW = $clog2(FALL_PERIOD);
    localparam logic [CW-1:0] TERM_CNT = CW'(FALL_PERIOD - 1);

    bird_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flap_q, flap_d;
    logic          fall_q, fall_d;
    logic          playing_q, playing_d;
    logic          dead_q, dead_d;
    logic          key_ev_s;

    key_pulse u_key_pulse (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .key_event (key_ev_s)
    );

    // Next-state, counter and strobe decode; hit outranks flap, flap outranks fall.
    always_comb begin
        state_d = state_q;
        cnt_d   = {CW{1'b0}};
        flap_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_ev_s) begin
                    state_d = PLAY;
                    flap_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                if (hit) begin
                    state_d = DEAD;
                end else if (key_ev_s) begin
                    flap_d = 1'b1;
                end else if (cnt_q == TERM_CNT) begin
                    fall_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DEAD: begin
                state_d = DEAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        playing_d = (state_d == PLAY);
        dead_d    = (state_d == DEAD);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            flap_q    <= 1'b0;
            fall_q    <= 1'b0;
            playing_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flap_q    <= flap_d;
            fall_q    <= fall_d;
            playing_q <= playing_d;
            dead_q    <= dead_d;
        end
    end

    assign flap    = flap_q;
    assign fall    = fall_q;
    assign playing = playing_q;
    assign dead    = dead_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Self-checking bench for bird_motion_ctrl: start table, corner sequences and
// randomized stimulus against an event-timing reference model.
module tb_bird_motion_ctrl;

    localparam int FP = 4;
`ifdef BIRD_KEY_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic key   = 1'b0;
    logic hit   = 1'b0;
    logic flap, fall, playing, dead;

    bird_motion_ctrl #(.FALL_PERIOD(FP)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .key     (key),
        .hit     (hit),
        .flap    (flap),
        .fall    (fall),
        .playing (playing),
        .dead    (dead)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic key;
        logic hit;
        logic flap;
        logic fall;
        logic play;
        logic dead;
    } vec_t;

    vec_t tbl [15];

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 play, 2 dead; gravity measured as
    // distance in edges from the last flap or fall.
    int         m_mode;
    int         m_n;
    int         m_last_ref;
    logic [3:0] m_hist;
    logic       e_flap, e_fall, e_play, e_dead;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_n        = 0;
        m_last_ref = 0;
        m_hist     = 4'b0000;
        e_flap     = 1'b0;
        e_fall     = 1'b0;
        e_play     = 1'b0;
        e_dead     = 1'b0;
    endtask

    task automatic model_edge(input logic k, input logic h);
        logic ev;
        m_n++;
        m_hist = {m_hist[2:0], k};
        ev     = m_hist[LAT] & ~m_hist[LAT+1];
        e_flap = 1'b0;
        e_fall = 1'b0;
        case (m_mode)
            0: begin
                if (ev) begin
                    m_mode = 1; e_flap = 1'b1; m_last_ref = m_n;
                end
            end
            1: begin
                if (h) begin
                    m_mode = 2;
                end else if (ev) begin
                    e_flap = 1'b1; m_last_ref = m_n;
                end else if (m_n - m_last_ref == FP) begin
                    e_fall = 1'b1; m_last_ref = m_n;
                end
            end
            default: ;
        endcase
        e_play = (m_mode == 1);
        e_dead = (m_mode == 2);
    endtask

    task automatic cyc(input logic k, input logic h);
        key = k;
        hit = h;
        model_edge(k, h);
        @(negedge clk);
        check("flap", flap, e_flap);
        check("fall", fall, e_fall);
        check("playing", playing, e_play);
        check("dead", dead, e_dead);
    endtask

    task automatic do_reset(input int ncyc, input logic k);
        rst_n = 1'b0;
        key   = k;
        hit   = 1'b0;
        #1;
        check("rst_flap", flap, 1'b0);
        check("rst_fall", fall, 1'b0);
        check("rst_playing", playing, 1'b0);
        check("rst_dead", dead, 1'b0);
        model_reset();
        repeat (ncyc) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: run still active, required finished");
        $fatal(1);
    end

    initial begin
        int  found;
        int  strobes;
        int  flaps;
        logic kv;
        logic hv;

        //            key   hit   flap  fall  play  dead
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        model_reset();

        // Reset, then idle with key low.
        do_reset(3, 1'b0);
        repeat (10) cyc(1'b0, 1'b0);

        // Start: key raised and held; without the synchronizer the idle row
        // before the flap is one shorter.
        do_reset(2, 1'b0);
        for (int i = 2 - LAT; i < 15; i++) begin
            cyc(tbl[i].key, tbl[i].hit);
            check("tbl_flap", flap, tbl[i].flap);
            check("tbl_fall", fall, tbl[i].fall);
            check("tbl_playing", playing, tbl[i].play);
            check("tbl_dead", dead, tbl[i].dead);
        end

        // Key event landing on terminal count.
        repeat (2) cyc(1'b0, 1'b0);
        for (int t = 0; t < 40 && ((m_n + 1 + LAT - m_last_ref) != FP); t++)
            cyc(1'b0, 1'b0);
        check("tc_align", ((m_n + 1 + LAT - m_last_ref) == FP), 1'b1);
        repeat (LAT) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        check("tc_flap", flap, 1'b1);
        check("tc_fall_suppressed", fall, 1'b0);
        repeat (3) begin
            cyc(1'b1, 1'b0);
            check("tc_no_early_fall", fall, 1'b0);
        end
        cyc(1'b1, 1'b0);
        check("tc_fall_after_period", fall, 1'b1);

        // Collision coinciding with a key event.
        repeat (2) cyc(1'b0, 1'b0);
        repeat (LAT) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("hit_dead", dead, 1'b1);
        check("hit_playing", playing, 1'b0);
        check("hit_flap", flap, 1'b0);
        check("hit_fall", fall, 1'b0);
        strobes = 0;
        repeat (3) begin
            repeat (2) begin cyc(1'b0, 1'b0); strobes += int'(flap) + int'(fall); end
            repeat (2) begin cyc(1'b1, 1'b1); strobes += int'(flap) + int'(fall); end
        end
        repeat (20) begin
            cyc(1'b0, 1'(($urandom_range(0, 1))));
            strobes += int'(flap) + int'(fall);
        end
        check("dead_no_strobes", (strobes == 0), 1'b1);
        check("dead_stays", dead, 1'b1);

        // Reset while dead returns to idle.
        do_reset(2, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        check("post_dead_idle_play", playing, 1'b0);
        check("post_dead_idle_dead", dead, 1'b0);

        // Reset while a fall pulse is high; key held through release.
        repeat (LAT + 1) cyc(1'b1, 1'b0);
        found = 0;
        for (int t = 0; t < 20 && found == 0; t++) begin
            cyc(1'b1, 1'b0);
            if (fall === 1'b1) found = 1;
        end
        check("fall_seen", (found == 1), 1'b1);
        do_reset(2, 1'b1);
        flaps = 0;
        repeat (LAT + 6) begin
            cyc(1'b1, 1'b0);
            flaps += int'(flap);
        end
        check("held_key_one_flap", (flaps == 1), 1'b1);

        // Randomized play against the model.
        kv = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ((m_mode == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3), kv);
            end else begin
                if ($urandom_range(0, 3) == 0) kv = ~kv;
                hv = ($urandom_range(0, 39) == 0);
                cyc(kv, hv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
